// File: rtl/queens_search_ctrl.sv
// Depth-first backtracking N-queens sequencer. It steps an external board datapath
// through check/place/erase moves and reports each solution to the host.
module queens_search_ctrl #(
  parameter int N   = 8,
  parameter int CW  = 3,
  parameter int SCW = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic           next,
  input  logic           stop,
  input  logic           safe,
  output logic [CW-1:0]  row_counter,
  output logic [CW-1:0]  clm_counter,
  output logic           update,
  output logic           fill_erase,
  output logic           busy,
  output logic           found,
  output logic           done,
  output logic [SCW-1:0] sol_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_PLACE,
    S_FOUND,
    S_BACK,
    S_ERASE,
    S_CLEAR,
    S_DONE
  } state_t;

  localparam logic [CW-1:0] LAST = CW'(N - 1);

  state_t        state, state_nxt;
  logic [CW-1:0] r, r_nxt;
  logic [CW-1:0] c, c_nxt;
  logic [CW-1:0] col_mem [N];
  logic [CW-1:0] disp_clm;
  logic          launch;
  logic          solved;

  // NOTE: next-state logic is combinational, so it uses blocking assignments and
  // gives every variable a default first; anything left unassigned would become a latch.
  always_comb begin
    state_nxt = state;
    r_nxt     = r;
    c_nxt     = c;
    unique case (state)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_nxt = S_CHECK;
          r_nxt     = '0;
          c_nxt     = '0;
        end
      end
      S_CHECK: begin
        if (safe)           state_nxt = S_PLACE;
        else if (c != LAST) c_nxt     = c + 1'b1;
        else                state_nxt = S_BACK;
      end
      S_PLACE: begin
        if (r == LAST) begin
          state_nxt = S_FOUND;
        end else begin
          state_nxt = S_CHECK;
          r_nxt     = r + 1'b1;
          c_nxt     = '0;
        end
      end
      S_FOUND: begin
        // stop takes priority over next when both are raised together
        if (stop)      state_nxt = S_CLEAR;
        else if (next) state_nxt = S_ERASE;
      end
      S_BACK: begin
        if (r == '0) begin
          state_nxt = S_DONE;
        end else begin
          state_nxt = S_ERASE;
          r_nxt     = r - 1'b1;
        end
      end
      S_ERASE: begin
        if (col_mem[r] != LAST) begin
          state_nxt = S_CHECK;
          c_nxt     = col_mem[r] + 1'b1;
        end else begin
          state_nxt = S_BACK;
        end
      end
      S_CLEAR: begin
        if (r == '0) state_nxt = S_DONE;
        else         r_nxt     = r - 1'b1;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Erase-type states address the queen recorded for the row; search states address (r, c).
  assign disp_clm = (state_nxt == S_ERASE || state_nxt == S_CLEAR) ? col_mem[r_nxt] : c_nxt;
  assign launch   = (state == S_IDLE || state == S_DONE) && start;
  assign solved   = (state == S_PLACE) && (r == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      r           <= '0;
      c           <= '0;
      // NOTE: col_mem is only N small words, so it is reset with the rest of the
      // state; a large RAM would instead be left unreset and written before use.
      for (int i = 0; i < N; i++) col_mem[i] <= '0;
      sol_count   <= '0;
      row_counter <= '0;
      clm_counter <= '0;
      update      <= 1'b0;
      fill_erase  <= 1'b0;
      busy        <= 1'b0;
      found       <= 1'b0;
      done        <= 1'b0;
    end else begin
      state <= state_nxt;
      r     <= r_nxt;
      c     <= c_nxt;

      if (state == S_PLACE) col_mem[r] <= c;

      if (launch)                           sol_count <= '0;
      else if (solved && sol_count != '1)   sol_count <= sol_count + 1'b1;

      // Selectors only move in states that address the board; elsewhere they hold.
      if (state_nxt == S_CHECK || state_nxt == S_PLACE ||
          state_nxt == S_ERASE || state_nxt == S_CLEAR) begin
        row_counter <= r_nxt;
        clm_counter <= disp_clm;
      end

      update     <= (state_nxt == S_PLACE) || (state_nxt == S_ERASE) || (state_nxt == S_CLEAR);
      fill_erase <= (state_nxt == S_PLACE);
      busy       <= !(state_nxt == S_IDLE || state_nxt == S_FOUND || state_nxt == S_DONE);
      found      <= (state_nxt == S_FOUND);
      done       <= (state_nxt == S_DONE);
    end
  end

endmodule
